alu_issue_stage: RTL and testbench

//  Buffered command/response stage wrapped around the 4-bit combinational ALU.
//  - Upstream producers push {op,a,b} commands over a valid/ready interface.
//  - The block queues them, drives the FIFO head onto the ALU inputs and

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_issue_stage_if.sv | 51 +++++
 rtl/alu_cmd_fifo.sv | 62 ++++++
 rtl/alu_issue_stage.sv | 107 ++++++++++
 tb/tb_alu_issue_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   alu_op_e    - 3-bit ALU opcode
//   alu_cmd_t   - {op, a, b} command payload
//   alu_flags_t - {carry, zero, overflow} result flags
//   rsp_state_e - response register occupancy
package alu_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    NOT = 3'd5,
    INC = 3'd6,
    DEC = 3'd7
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic overflow;
  } alu_flags_t;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: bundles the command, ALU and response channels of
// the issue stage.
//   slave  - the issue stage itself (takes commands, drives ALU inputs,
//            returns responses)
//   master - the surrounding environment (producer, ALU, consumer)
interface alu_issue_stage_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) ();
  import alu_pkg::*;

  // command channel
  logic                   cmd_valid;
  logic                   cmd_ready;
  alu_op_e                cmd_op;
  logic [DATA_W-1:0]      cmd_a;
  logic [DATA_W-1:0]      cmd_b;
  // ALU side
  alu_op_e                alu_op;
  logic [DATA_W-1:0]      alu_a;
  logic [DATA_W-1:0]      alu_b;
  logic [DATA_W-1:0]      alu_result;
  logic                   alu_carry;
  logic                   alu_zero;
  logic                   alu_overflow;
  // response channel
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [DATA_W-1:0]      rsp_result;
  logic [2:0]             rsp_flags;
  logic [TAG_W-1:0]       rsp_tag;
  // status
  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  alu_result, alu_carry, alu_zero, alu_overflow,
    input  rsp_ready,
    output cmd_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_flags, rsp_tag, fifo_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output alu_result, alu_carry, alu_zero, alu_overflow,
    output rsp_ready,
    input  cmd_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_flags, rsp_tag, fifo_count
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: generic synchronous FIFO with a show-ahead head output.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (pointers/count only)
//   push       - write push_data (ignored when full)
//   push_data  - payload written on push
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry (undefined while empty)
//   full/empty - occupancy flags
//   count      - number of entries held, 0..DEPTH
module alu_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T                mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // storage carries no reset; only the pointers and count define contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // pointers are exactly log2(DEPTH) bits, so they wrap without compare logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: buffered command/response stage around an external
// combinational 4-bit ALU.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_issue_stage_if.slave:
//          cmd_*      valid/ready command input {op,a,b}
//          alu_*      FIFO head to the ALU, ALU result/flags back
//          rsp_*      registered result, flags {carry,zero,overflow}, tag
//          fifo_count entries currently queued
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus
);

  typedef struct packed {
    alu_cmd_t         cmd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic              full;
  logic              empty;
  logic              push;
  logic              issue;
  logic [TAG_W-1:0]  tag_cnt;

  rsp_state_e        state;
  logic [DATA_W-1:0] rsp_result;
  alu_flags_t        rsp_flags;
  logic [TAG_W-1:0]  rsp_tag;

  // cmd_ready looks only at the registered count, so a pop in the same
  // cycle never opens the door for a push into a full FIFO
  assign bus.cmd_ready = ~full;
  assign push          = bus.cmd_valid & ~full;
  assign issue         = ~empty & ((state == RSP_EMPTY) | bus.rsp_ready);

  assign wr_entry.cmd.op = bus.cmd_op;
  assign wr_entry.cmd.a  = bus.cmd_a;
  assign wr_entry.cmd.b  = bus.cmd_b;
  assign wr_entry.tag    = tag_cnt;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (wr_entry),
    .pop       (issue),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (bus.fifo_count)
  );

  // head onto the ALU; zeros while empty so the ALU inputs are quiet
  always_comb begin
    bus.alu_op = ADD;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    if (!empty) begin
      bus.alu_op = head.cmd.op;
      bus.alu_a  = head.cmd.a;
      bus.alu_b  = head.cmd.b;
    end
  end

  // response register: ALU output captured on issue, held while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RSP_EMPTY;
      tag_cnt    <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
    end else begin
      if (push) tag_cnt <= tag_cnt + TAG_W'(1);
      if (issue) begin
        rsp_result <= bus.alu_result;
        rsp_flags  <= '{carry: bus.alu_carry, zero: bus.alu_zero,
                        overflow: bus.alu_overflow};
        rsp_tag    <= head.tag;
      end
      case (state)
        RSP_EMPTY: if (issue) state <= RSP_FULL;
        RSP_FULL:  if (bus.rsp_ready && !issue) state <= RSP_EMPTY;
        default:   state <= RSP_EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid  = (state == RSP_FULL);
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_flags  = rsp_flags;
  assign bus.rsp_tag    = rsp_tag;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: bench for alu_issue_stage. Models the combinational
// ALU, keeps a queue of expected responses filled on command accept and
// drained on response handshake, plus directed checks on reset, latency,
// stall, full-FIFO and tag wrap behaviour.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_issue_stage_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) ifc ();

  alu_issue_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference ALU: returns {result[3:0], carry, zero, overflow}
  function automatic logic [6:0] alu_model(input alu_op_e op, input logic [3:0] a,
                                           input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                 v = (a[3] == b[3]) && (r[3] != a[3]); end
      SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
                 v = (a[3] != b[3]) && (r[3] != a[3]); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      NOT: r = ~a;
      INC: begin s = {1'b0, a} + 5'd1; r = s[3:0]; c = s[4]; v = (a == 4'd7); end
      default: begin s = {1'b0, a} - 5'd1; r = s[3:0]; c = s[4]; v = (a == 4'd8); end
    endcase
    return {r, c, (r == 4'd0), v};
  endfunction

  logic [6:0] alu_out;
  always_comb begin
    alu_out          = alu_model(ifc.alu_op, ifc.alu_a, ifc.alu_b);
    ifc.alu_result   = alu_out[6:3];
    ifc.alu_carry    = alu_out[2];
    ifc.alu_zero     = alu_out[1];
    ifc.alu_overflow = alu_out[0];
  end

  // scoreboard entry: {result[3:0], flags[2:0], tag[3:0]}
  logic [10:0]      sb[$];
  logic [TAG_W-1:0] tag_exp;
  logic [10:0]      sb_e;
  logic [6:0]       sb_m;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      tag_exp = '0;
    end else begin
      if (ifc.cmd_valid && ifc.cmd_ready) begin
        sb_m = alu_model(ifc.cmd_op, ifc.cmd_a, ifc.cmd_b);
        sb.push_back({sb_m, tag_exp});
        tag_exp = tag_exp + 4'd1;
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          sb_e = sb.pop_front();
          chk("sb_result", 32'(ifc.rsp_result), 32'(sb_e[10:7]));
          chk("sb_flags",  32'(ifc.rsp_flags),  32'(sb_e[6:4]));
          chk("sb_tag",    32'(ifc.rsp_tag),    32'(sb_e[3:0]));
        end
      end
    end
  end

  bit rand_rdy = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input alu_op_e op, input logic [3:0] a, input logic [3:0] b);
    bit accepted = 1'b0;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_a     = a;
    ifc.cmd_b     = b;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (rand_rdy) ifc.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ifc.cmd_ready) accepted = 1'b1;
      step();
    end
    ifc.cmd_valid = 1'b0;
    if (!accepted) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (ifc.fifo_count == '0 && !ifc.rsp_valid) done = 1'b1;
      else step();
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [3:0] hold_res;
  logic [2:0] hold_flg;
  logic [3:0] hold_tag;

  initial begin
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = ADD;
    ifc.cmd_a     = '0;
    ifc.cmd_b     = '0;
    ifc.rsp_ready = 1'b0;

    // reset state while rst is held
    repeat (3) step();
    chk("rst_count",  32'(ifc.fifo_count), 32'd0);
    chk("rst_valid",  32'(ifc.rsp_valid),  32'd0);
    chk("rst_ready",  32'(ifc.cmd_ready),  32'd1);
    chk("rst_result", 32'(ifc.rsp_result), 32'd0);
    chk("rst_flags",  32'(ifc.rsp_flags),  32'd0);
    chk("rst_tag",    32'(ifc.rsp_tag),    32'd0);
    rst = 1'b0;
    step();

    // ADD 9+8: 17 -> result 1, carry, signed -7 + -8 overflows
    ifc.rsp_ready = 1'b1;
    push_cmd(ADD, 4'd9, 4'd8);
    chk("lat_no_bypass", 32'(ifc.rsp_valid),  32'd0);
    chk("lat_count",     32'(ifc.fifo_count), 32'd1);
    step();
    chk("add_valid",  32'(ifc.rsp_valid),  32'd1);
    chk("add_result", 32'(ifc.rsp_result), 32'd1);
    chk("add_flags",  32'(ifc.rsp_flags),  32'b101);
    chk("add_tag",    32'(ifc.rsp_tag),    32'd0);
    drain();

    // SUB 3-3 then DEC 0
    push_cmd(SUB, 4'd3, 4'd3);
    push_cmd(DEC, 4'd0, 4'd0);
    chk("sub_result", 32'(ifc.rsp_result), 32'd0);
    chk("sub_zero",   32'(ifc.rsp_flags[1]), 32'd1);
    step();
    chk("dec_result", 32'(ifc.rsp_result), 32'd15);
    chk("dec_zero",   32'(ifc.rsp_flags[1]), 32'd0);
    chk("dec_tag",    32'(ifc.rsp_tag),    32'd2);
    drain();

    // stall: one held in the response register, four queued
    ifc.rsp_ready = 1'b0;
    push_cmd(XOR, 4'd5, 4'd3);
    push_cmd(INC, 4'd7, 4'd0);
    push_cmd(OR,  4'd8, 4'd1);
    push_cmd(NOT, 4'd6, 4'd0);
    push_cmd(AND, 4'd12, 4'd10);
    chk("full_count", 32'(ifc.fifo_count), 32'd4);
    chk("full_ready", 32'(ifc.cmd_ready),  32'd0);
    chk("stall_tag0", 32'(ifc.rsp_tag),    32'd3);
    chk("stall_res0", 32'(ifc.rsp_result), 32'd6);
    hold_res = ifc.rsp_result;
    hold_flg = ifc.rsp_flags;
    hold_tag = ifc.rsp_tag;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_result", 32'(ifc.rsp_result), 32'(hold_res));
      chk("stall_flags",  32'(ifc.rsp_flags),  32'(hold_flg));
      chk("stall_tag",    32'(ifc.rsp_tag),    32'(hold_tag));
    end

    // full: a pop this cycle must not make cmd_ready rise until next cycle
    ifc.rsp_ready = 1'b1;
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = SUB;
    ifc.cmd_a     = 4'd2;
    ifc.cmd_b     = 4'd9;
    @(negedge clk);
    chk("full_pop_ready", 32'(ifc.cmd_ready), 32'd0);
    step();
    chk("after_pop_ready", 32'(ifc.cmd_ready),  32'd1);
    chk("after_pop_count", 32'(ifc.fifo_count), 32'd3);
    step();
    ifc.cmd_valid = 1'b0;
    chk("pushpop_count", 32'(ifc.fifo_count), 32'd3);
    drain();

    // random traffic with random backpressure; tags wrap 15 -> 0
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push_cmd(alu_op_e'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)));
    end
    rand_rdy = 1'b0;
    drain();

    // reset mid-stream with three queued
    ifc.rsp_ready = 1'b0;
    push_cmd(ADD, 4'd1, 4'd2);
    push_cmd(ADD, 4'd3, 4'd4);
    push_cmd(ADD, 4'd5, 4'd6);
    push_cmd(ADD, 4'd7, 4'd8);
    chk("pre_rst_count", 32'(ifc.fifo_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(ifc.fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(ifc.rsp_valid),  32'd0);
    chk("mid_rst_ready", 32'(ifc.cmd_ready),  32'd1);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", 32'(ifc.fifo_count), 32'd0);
    chk("post_rst_valid", 32'(ifc.rsp_valid),  32'd0);
    ifc.rsp_ready = 1'b1;
    push_cmd(ADD, 4'd1, 4'd1);
    step();
    chk("post_rst_tag",    32'(ifc.rsp_tag),    32'd0);
    chk("post_rst_result", 32'(ifc.rsp_result), 32'd2);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
